// File: rtl/game_controller.sv
// Game flow controller: IDLE/RUN/CRASH/OVER sequencing, update/scroll pulse dividers and LFSR spawn requests.
// Define RR_LIVES_EN to enable the multi-life counter; otherwise every crash ends the game with lives fixed at 1.
module game_controller #(
   parameter int UP_DIV       = 833333,
   parameter int FAST_DIV     = 416667,
   parameter int CRASH_CYCLES = 50000000,
   parameter int LIVES        = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       colision,
   output logic       upsig,
   output logic       upsig_fast,
   output logic       drop,
   output logic       alive,
   output logic [1:0] lives,
   output logic [1:0] state_dbg
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      CRASH = 2'd2,
      OVER  = 2'd3
   } state_t;

   localparam int UP_W    = $clog2(UP_DIV + 1);
   localparam int FAST_W  = $clog2(FAST_DIV + 1);
   localparam int CRASH_W = $clog2(CRASH_CYCLES + 1);

   // A divider of N pulses when its counter sits at N-2, so the register lands on the N-th RUN clock.
   localparam logic [UP_W-1:0]    UP_LAST    = UP_W'(UP_DIV - 1);
   localparam logic [UP_W-1:0]    UP_PRE     = UP_W'((UP_DIV > 1) ? UP_DIV - 2 : 0);
   localparam logic [FAST_W-1:0]  FAST_LAST  = FAST_W'(FAST_DIV - 1);
   localparam logic [FAST_W-1:0]  FAST_PRE   = FAST_W'((FAST_DIV > 1) ? FAST_DIV - 2 : 0);
   localparam logic [CRASH_W-1:0] CRASH_LAST = CRASH_W'(CRASH_CYCLES - 1);
   localparam logic               UP_EVERY   = (UP_DIV == 1);
   localparam logic               FAST_EVERY = (FAST_DIV == 1);

`ifdef RR_LIVES_EN
   localparam logic [1:0] LIVES_LOAD = 2'(LIVES);
`else
   localparam logic [1:0] LIVES_LOAD = (LIVES >= 1) ? 2'd1 : 2'd1;
`endif

   state_t             state, next_state;
   logic               start_q;
   logic               start_evt;
   logic [1:0]         lives_next;
   logic [UP_W-1:0]    up_cnt, up_cnt_next;
   logic [FAST_W-1:0]  fast_cnt, fast_cnt_next;
   logic [CRASH_W-1:0] crash_cnt, crash_cnt_next;
   logic [7:0]         lfsr, lfsr_next;
   logic               upsig_next, upsig_fast_next, drop_next;

   assign state_dbg = state;
   assign alive     = (state == RUN);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         start_q    <= 1'b0;
         lives      <= 2'd0;
         up_cnt     <= '0;
         fast_cnt   <= '0;
         crash_cnt  <= '0;
         lfsr       <= 8'hA5;
         upsig      <= 1'b0;
         upsig_fast <= 1'b0;
         drop       <= 1'b0;
      end else begin
         state      <= next_state;
         start_q    <= start;
         lives      <= lives_next;
         up_cnt     <= up_cnt_next;
         fast_cnt   <= fast_cnt_next;
         crash_cnt  <= crash_cnt_next;
         lfsr       <= lfsr_next;
         upsig      <= upsig_next;
         upsig_fast <= upsig_fast_next;
         drop       <= drop_next;
      end
   end

   always_comb begin
      start_evt       = start & ~start_q;
      next_state      = state;
      lives_next      = lives;
      up_cnt_next     = up_cnt;
      fast_cnt_next   = fast_cnt;
      crash_cnt_next  = crash_cnt;
      upsig_next      = 1'b0;
      upsig_fast_next = 1'b0;

      case (state)
         IDLE, OVER: begin
            if (start_evt) begin
               next_state      = RUN;
               lives_next      = LIVES_LOAD;
               up_cnt_next     = '0;
               fast_cnt_next   = '0;
               upsig_next      = UP_EVERY;
               upsig_fast_next = FAST_EVERY;
            end
         end
         RUN: begin
            // Collision takes priority; a start edge during RUN has no effect.
            if (colision) begin
               next_state     = CRASH;
               crash_cnt_next = '0;
`ifdef RR_LIVES_EN
               lives_next     = (lives == 2'd0) ? 2'd0 : lives - 2'd1;
`endif
            end else begin
               up_cnt_next     = (up_cnt == UP_LAST) ? '0 : up_cnt + 1'b1;
               fast_cnt_next   = (fast_cnt == FAST_LAST) ? '0 : fast_cnt + 1'b1;
               upsig_next      = UP_EVERY | (up_cnt == UP_PRE);
               upsig_fast_next = FAST_EVERY | (fast_cnt == FAST_PRE);
            end
         end
         CRASH: begin
            if (crash_cnt == CRASH_LAST) begin
               crash_cnt_next = '0;
`ifdef RR_LIVES_EN
               if (lives == 2'd0) begin
                  next_state = OVER;
               end else begin
                  next_state      = RUN;
                  up_cnt_next     = '0;
                  fast_cnt_next   = '0;
                  upsig_next      = UP_EVERY;
                  upsig_fast_next = FAST_EVERY;
               end
`else
               next_state = OVER;
`endif
            end else begin
               crash_cnt_next = crash_cnt + 1'b1;
            end
         end
         default: next_state = IDLE;
      endcase

      drop_next = upsig_next & (lfsr[2:0] == 3'b000);
      lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
   end

endmodule
